// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;
  localparam int DATA_W     = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: one instance per requesting port.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_arbiter_pick2.sv
// Combinational two-way winner select: round-robin on ties, or fixed port-0
// priority overridden by the starvation flag.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_id_t   rr_last_i,
  input  logic       mode_i,
  input  logic       starve_i,
  output logic       valid_o,
  output port_id_t   winner_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = 1'b0;
    if (req_i == 2'b11) begin
      winner_o = mode_i ? starve_i : ~rr_last_i;
    end else begin
      winner_o = req_i[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between two requesters with a fixed
// ARB -> ACCESS -> RESP transaction (one access every three cycles at most).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  mem_arbiter_if.slave      m0,
  mem_arbiter_if.slave      m1,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o32,
  output logic [DATA_W-1:0] mem_wdata_o32,
  input  logic [DATA_W-1:0] mem_rdata_i32
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic       FIXED_C    = (PRIO_MODE == PRIO_FIXED);

  arb_state_t        state_q, state_d;
  port_id_t          owner_q, owner_d;
  port_id_t          rr_last_q, rr_last_d;
  logic [3:0]        wait_q, wait_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic     pick_valid;
  port_id_t winner;
  logic     access_act;
  logic     resp_act;

  arb_pick2 u_pick (
    .req_i     ({m1.req, m0.req}),
    .rr_last_i (rr_last_q),
    .mode_i    (FIXED_C),
    .starve_i  (wait_q == MAX_WAIT_C),
    .valid_o   (pick_valid),
    .winner_o  (winner)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_ARB;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      wait_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      wait_q    <= wait_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    wait_d    = wait_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    unique case (state_q)
      ST_ARB: begin
        if (pick_valid) begin
          state_d   = ST_ACCESS;
          owner_d   = winner;
          rr_last_d = winner;
          we_d      = winner ? m1.we    : m0.we;
          addr_d    = winner ? m1.addr  : m0.addr;
          wdata_d   = winner ? m1.wdata : m0.wdata;
          // Losses only count while port 1 is actually waiting; saturate at the limit.
          if (FIXED_C) begin
            if (winner) begin
              wait_d = '0;
            end else if (m1.req && (wait_q != MAX_WAIT_C)) begin
              wait_d = wait_q + 4'd1;
            end
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (!we_q) begin
          if (owner_q) rdata1_d = mem_rdata_i32;
          else         rdata0_d = mem_rdata_i32;
        end
      end
      ST_RESP: state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Reset masks the strobes so an aborted transaction never writes or handshakes.
  assign access_act = (state_q == ST_ACCESS) && !reset_i;
  assign resp_act   = (state_q == ST_RESP) && !reset_i;

  assign m0.gnt    = access_act && (owner_q == 1'b0);
  assign m1.gnt    = access_act && (owner_q == 1'b1);
  assign m0.rvalid = resp_act && (owner_q == 1'b0);
  assign m1.rvalid = resp_act && (owner_q == 1'b1);
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

  assign mem_we_o      = access_act && we_q;
  assign mem_addr_o32  = addr_q;
  assign mem_wdata_o32 = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance side by side,
// a transaction-level reference model feeding a scoreboard, directed and random traffic.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int MAXW = 4;
  localparam int NW   = 64;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
  } txn_t;

  typedef struct {
    int          cyc;
    bit          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [31:0] old;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic load_mem;
  always #5 clk = ~clk;

  // index k = 2*dut + port; dut 0 = round-robin, dut 1 = fixed priority
  logic [3:0]       req, we, gnt, rvalid;
  logic [3:0][31:0] addr, wdata, rdata;
  logic [1:0]       mem_we;
  logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0]      tbmem [2][NW];

  mem_arbiter_if rr_m0 ();
  mem_arbiter_if rr_m1 ();
  mem_arbiter_if fx_m0 ();
  mem_arbiter_if fx_m1 ();

  assign rr_m0.req = req[0]; assign rr_m0.we = we[0]; assign rr_m0.addr = addr[0]; assign rr_m0.wdata = wdata[0];
  assign rr_m1.req = req[1]; assign rr_m1.we = we[1]; assign rr_m1.addr = addr[1]; assign rr_m1.wdata = wdata[1];
  assign fx_m0.req = req[2]; assign fx_m0.we = we[2]; assign fx_m0.addr = addr[2]; assign fx_m0.wdata = wdata[2];
  assign fx_m1.req = req[3]; assign fx_m1.we = we[3]; assign fx_m1.addr = addr[3]; assign fx_m1.wdata = wdata[3];
  assign gnt[0] = rr_m0.gnt; assign rvalid[0] = rr_m0.rvalid; assign rdata[0] = rr_m0.rdata;
  assign gnt[1] = rr_m1.gnt; assign rvalid[1] = rr_m1.rvalid; assign rdata[1] = rr_m1.rdata;
  assign gnt[2] = fx_m0.gnt; assign rvalid[2] = fx_m0.rvalid; assign rdata[2] = fx_m0.rdata;
  assign gnt[3] = fx_m1.gnt; assign rvalid[3] = fx_m1.rvalid; assign rdata[3] = fx_m1.rdata;
  assign mem_rdata[0] = tbmem[0][mem_addr[0][7:2]];
  assign mem_rdata[1] = tbmem[1][mem_addr[1][7:2]];

  mem_arbiter #(.PRIO_MODE(0), .MAX_WAIT(MAXW)) u_rr (
    .clk_i(clk), .reset_i(rst), .m0(rr_m0), .m1(rr_m1),
    .mem_we_o(mem_we[0]), .mem_addr_o32(mem_addr[0]),
    .mem_wdata_o32(mem_wdata[0]), .mem_rdata_i32(mem_rdata[0])
  );

  mem_arbiter #(.PRIO_MODE(1), .MAX_WAIT(MAXW)) u_fx (
    .clk_i(clk), .reset_i(rst), .m0(fx_m0), .m1(fx_m1),
    .mem_we_o(mem_we[1]), .mem_addr_o32(mem_addr[1]),
    .mem_wdata_o32(mem_wdata[1]), .mem_rdata_i32(mem_rdata[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  txn_t        txq [4][$];
  int          dcnt [4];
  exp_t        gq [2][$];
  int          glog [2][$];
  int          gcyc [2][$];
  logic [31:0] mmem [2][NW];
  logic [31:0] exp_rd [4];
  int          busy [2];
  bit          rr_last [2];
  int          wcnt [2];

  int exp_rr [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  int exp_fx [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  function automatic logic [31:0] init_word(input int i);
    if (i == 32) return 32'h1234_5678;
    return 32'hA000_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a decision is possible whenever the arbiter is not inside a
  // transaction; each transaction occupies the decision cycle plus two more.
  task automatic model_step();
    exp_t e;
    bit   win;
    bit   r0, r1;
    int   k, idx;
    cyc++;
    if (load_mem) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < NW; i++) begin
          tbmem[d][i] = init_word(i);
          mmem[d][i]  = init_word(i);
        end
    end
    for (int d = 0; d < 2; d++) begin
      r0 = req[2*d];
      r1 = req[2*d+1];
      if (rst) begin
        busy[d] = 0; rr_last[d] = 1'b1; wcnt[d] = 0;
        exp_rd[2*d] = '0; exp_rd[2*d+1] = '0;
      end else if (busy[d] > 0) begin
        busy[d]--;
      end else if (r0 || r1) begin
        if (r0 && r1) win = (d == 0) ? !rr_last[d] : (wcnt[d] == MAXW);
        else          win = r1;
        if (d == 1) begin
          if (win) wcnt[d] = 0;
          else if (r1 && wcnt[d] < MAXW) wcnt[d]++;
        end
        rr_last[d] = win;
        k   = 2*d + (win ? 1 : 0);
        idx = int'(addr[k][7:2]);
        e.cyc = cyc; e.port = win; e.we = we[k]; e.addr = addr[k]; e.wdata = wdata[k];
        e.old = mmem[d][idx];
        if (we[k]) begin
          mmem[d][idx] = wdata[k];
          e.rd = exp_rd[k];
        end else begin
          e.rd = mmem[d][idx];
        end
        exp_rd[k] = e.rd;
        gq[d].push_back(e);
        busy[d] = 2;
      end
    end
  endtask

  task automatic monitor_step();
    exp_t       e;
    logic [1:0] g, v, eg, ev;
    bit         hg, hv;
    int         k, ko;
    for (int d = 0; d < 2; d++) begin
      g = {gnt[2*d+1], gnt[2*d]};
      v = {rvalid[2*d+1], rvalid[2*d]};
      if (rst) begin
        chk($sformatf("d%0d_reset_strobes", d), {27'd0, mem_we[d], v, g}, 32'd0);
        while (gq[d].size() > 0) begin
          e = gq[d].pop_back();
          if (e.cyc >= cyc && e.we) mmem[d][int'(e.addr[7:2])] = e.old;
        end
      end else begin
        hg = 1'b0; hv = 1'b0;
        if (gq[d].size() > 0) begin
          e = gq[d][0];
          if (e.cyc + 1 < cyc) begin
            chk($sformatf("d%0d_txn_lost", d), 32'd0, 32'd1);
            void'(gq[d].pop_front());
          end else begin
            hg = (e.cyc == cyc);
            hv = (e.cyc + 1 == cyc);
          end
        end
        eg = hg ? (e.port ? 2'b10 : 2'b01) : 2'b00;
        ev = hv ? (e.port ? 2'b10 : 2'b01) : 2'b00;
        chk($sformatf("d%0d_gnt", d), 32'(g), 32'(eg));
        chk($sformatf("d%0d_rvalid", d), 32'(v), 32'(ev));
        chk($sformatf("d%0d_mem_we", d), 32'(mem_we[d]), 32'(hg && e.we));
        if (hg) begin
          chk($sformatf("d%0d_mem_addr", d), mem_addr[d], e.addr);
          if (e.we) chk($sformatf("d%0d_mem_wdata", d), mem_wdata[d], e.wdata);
          if (g == eg) begin
            glog[d].push_back(e.port ? 1 : 0);
            gcyc[d].push_back(cyc);
          end
        end
        if (hv) begin
          k  = 2*d + (e.port ? 1 : 0);
          ko = 2*d + (e.port ? 0 : 1);
          chk($sformatf("d%0d_p%0d_rdata", d, e.port), rdata[k], e.rd);
          chk($sformatf("d%0d_other_rdata", d), rdata[ko], exp_rd[ko]);
          void'(gq[d].pop_front());
        end
        if (mem_we[d]) tbmem[d][mem_addr[d][7:2]] = mem_wdata[d];
      end
    end
  endtask

  task automatic driver_step();
    txn_t t;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        req[k] = 1'b0;
        txq[k].delete();
        dcnt[k] = 0;
      end else begin
        if (req[k] && gnt[k]) begin
          void'(txq[k].pop_front());
          req[k]  = 1'b0;
          dcnt[k] = 0;
        end
        if (!req[k] && txq[k].size() > 0) begin
          t = txq[k][0];
          if (dcnt[k] >= t.dly) begin
            req[k] = 1'b1; we[k] = t.we; addr[k] = t.addr; wdata[k] = t.wdata;
            dcnt[k] = 0;
          end else begin
            dcnt[k]++;
          end
        end
      end
    end
  endtask

  initial begin
    req = '0; we = '0; addr = '0; wdata = '0;
    for (int k = 0; k < 4; k++) dcnt[k] = 0;
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      monitor_step();
      driver_step();
    end
  end

  task automatic push(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input int dl);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = wd; t.dly = dl;
    txq[k].push_back(t);
  endtask

  task automatic push_both(input int p, input logic w, input logic [31:0] a, input logic [31:0] wd);
    push(p, w, a, wd, 0);
    push(p + 2, w, a, wd, 0);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!(txq[0].size() == 0 && txq[1].size() == 0 && txq[2].size() == 0 &&
             txq[3].size() == 0 && req == 4'b0 && gq[0].size() == 0 &&
             gq[1].size() == 0) && n < bound) begin
      @(posedge clk);
      n++;
    end
    chk("idle_within_bound", 32'(n < bound), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int          n, c0;
    logic [31:0] orig0, orig1;
    rst = 1'b1;
    load_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    load_mem = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_reset_mem_we", d), 32'(mem_we[d]), 32'd0);
      chk($sformatf("d%0d_reset_mem_addr", d), mem_addr[d], 32'd0);
      chk($sformatf("d%0d_reset_mem_wdata", d), mem_wdata[d], 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("k%0d_reset_gnt_rvalid", k), {30'd0, gnt[k], rvalid[k]}, 32'd0);
      chk($sformatf("k%0d_reset_rdata", k), rdata[k], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // m0 write then read back
    push_both(0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    push_both(0, 1'b0, 32'h40, 32'h0);
    wait_idle(200);
    chk("rr_mem_0x40", tbmem[0][16], 32'hDEAD_BEEF);
    chk("fx_mem_0x40", tbmem[1][16], 32'hDEAD_BEEF);
    chk("rr_m0_rdata_0x40", rdata[0], 32'hDEAD_BEEF);
    chk("fx_m0_rdata_0x40", rdata[2], 32'hDEAD_BEEF);

    // m1 read with m0 idle
    push_both(1, 1'b0, 32'h80, 32'h0);
    wait_idle(200);
    chk("rr_m1_rdata_0x80", rdata[1], 32'h1234_5678);
    chk("fx_m1_rdata_0x80", rdata[3], 32'h1234_5678);
    chk("rr_m0_rdata_kept", rdata[0], 32'hDEAD_BEEF);

    // both ports requesting continuously
    for (int d = 0; d < 2; d++) begin glog[d].delete(); gcyc[d].delete(); end
    for (int i = 0; i < 12; i++)
      for (int k = 0; k < 4; k++)
        push(k, 1'b0, {24'd0, 6'($urandom_range(0, NW - 1)), 2'b00}, 32'h0, 0);
    wait_idle(600);
    chk("rr_glog_len", 32'(glog[0].size() >= 10), 32'd1);
    chk("fx_glog_len", 32'(glog[1].size() >= 10), 32'd1);
    if (glog[0].size() >= 10 && glog[1].size() >= 10) begin
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("rr_order_%0d", i), 32'(glog[0][i]), 32'(exp_rr[i]));
        chk($sformatf("fx_order_%0d", i), 32'(glog[1][i]), 32'(exp_fx[i]));
        if (i > 0) begin
          chk($sformatf("rr_gnt_spacing_%0d", i), 32'(gcyc[0][i] - gcyc[0][i-1]), 32'd3);
          chk($sformatf("fx_gnt_spacing_%0d", i), 32'(gcyc[1][i] - gcyc[1][i-1]), 32'd3);
        end
      end
    end

    // m0 request rising during RESP of an m1 transaction
    push_both(1, 1'b0, 32'h44, 32'h0);
    n = 0;
    while (!gnt[1] && n < 50) begin @(posedge clk); #1; n++; end
    chk("t6_m1_gnt_seen", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    chk("t6_m1_rvalid_in_resp", 32'(rvalid[1]), 32'd1);
    push_both(0, 1'b0, 32'h40, 32'h0);
    c0 = cyc;
    n = 0;
    while (!gnt[0] && n < 50) begin @(posedge clk); #1; n++; end
    chk("t6_m0_gnt_delay", 32'(cyc - c0), 32'd2);
    wait_idle(200);

    // random traffic
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 40; i++)
        push(k, 1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, NW - 1)), 2'b00},
             $urandom, $urandom_range(0, 4));
    wait_idle(3000);

    // reset while a write is in ACCESS
    orig0 = tbmem[0][48];
    orig1 = tbmem[1][48];
    push_both(0, 1'b1, 32'hC0, 32'h5555_AAAA);
    n = 0;
    while (!gnt[0] && n < 50) begin @(posedge clk); #1; n++; end
    chk("t1_gnt_before_reset", 32'(n < 50), 32'd1);
    rst = 1'b1;
    #1;
    chk("t1_rr_mem_we_in_reset", 32'(mem_we[0]), 32'd0);
    chk("t1_fx_mem_we_in_reset", 32'(mem_we[1]), 32'd0);
    chk("t1_gnt_in_reset", 32'({gnt[0], gnt[2]}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t1_rr_mem_unchanged", tbmem[0][48], orig0);
    chk("t1_fx_mem_unchanged", tbmem[1][48], orig1);
    for (int k = 0; k < 4; k++) chk($sformatf("t1_k%0d_rdata_cleared", k), rdata[k], 32'd0);
    push_both(0, 1'b0, 32'hC0, 32'h0);
    wait_idle(200);
    chk("t1_rr_readback", rdata[0], orig0);
    chk("t1_fx_readback", rdata[2], orig1);

    chk("scoreboard_drained", 32'(gq[0].size() + gq[1].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
